// File: rtl/jk_bank_sched.sv
// ============================================================================
// Module   : jk_bank_sched
// Purpose  : Command sequencer that drives J/K of an external WIDTH-bit JK
//            flip-flop bank to load, clear or count it for N clock edges.
// Options  : define JK_BANK_SCHED_SAT_EN to make counting saturate, not wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_bank_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_op_load  = 2'b00;
  localparam logic [1:0] c_op_up    = 2'b01;
  localparam logic [1:0] c_op_down  = 2'b10;
  localparam logic [1:0] c_op_clear = 2'b11;

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    c_idle = 2'd0,
    c_run  = 2'd1,
    c_done = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;
  logic             w_sat;
  logic             w_is_count;

  assign cmd_ready  = (r_state == c_idle);
  assign busy       = (r_state == c_run);
  assign done       = (r_state == c_done);
  assign w_is_count = (cmd_op == c_op_up) || (cmd_op == c_op_down);

  // Ripple-carry/borrow toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic a1;
    logic a0;
    a1   = 1'b1;
    a0   = 1'b1;
    w_up = '0;
    w_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_up[i] = a1;
      w_dn[i] = a0;
      a1      = a1 & Q[i];
      a0      = a0 & ~Q[i];
    end
  end

`ifdef JK_BANK_SCHED_SAT_EN
  assign w_sat = ((r_op == c_op_up) && (&Q)) || ((r_op == c_op_down) && (~|Q));
`else
  assign w_sat = 1'b0;
`endif

  always_comb begin
    J = '0;
    K = '0;
    if (r_state == c_run) begin
      case (r_op)
        c_op_load: begin
          J = r_data;
          K = ~r_data;
        end
        c_op_clear: begin
          J = '0;
          K = '1;
        end
        c_op_up: begin
          if (!w_sat) begin
            J = w_up;
            K = w_up;
          end
        end
        default: begin
          if (!w_sat) begin
            J = w_dn;
            K = w_dn;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= c_idle;
      r_op    <= 2'b00;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (cmd_valid && cmd_ready) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_cnt  <= cmd_len;
            // A zero-length count drives no bank edge at all.
            if (w_is_count && (cmd_len == '0)) begin
              r_state <= c_done;
            end else begin
              r_state <= c_run;
            end
          end
        end
        c_run: begin
          if ((r_op == c_op_load) || (r_op == c_op_clear)) begin
            r_state <= c_done;
          end else begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_one;
            end
            if (w_sat || (r_cnt <= c_one)) begin
              r_state <= c_done;
            end
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_sched.sv
// ============================================================================
// Module   : tb_jk_bank_sched
// Purpose  : Scoreboard bench for jk_bank_sched with a behavioural JK bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_bank_sched;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
`ifdef JK_BANK_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             bank_ld;
  logic [WIDTH-1:0] bank_val;

  logic [WIDTH-1:0] exp_q[$];
  int               n_chk;
  int               n_bad;

  jk_bank_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .Q         (q),
    .J         (j),
    .K         (k),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank of plain JK flip-flops with a bench-side preload path; it has no reset.
  always_ff @(posedge clk) begin
    if (bank_ld) q <= bank_val;
    else         q <= (j & ~q) | (~k & q);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bank(input logic [WIDTH-1:0] v);
    bank_ld  = 1'b1;
    bank_val = v;
    @(negedge clk);
    bank_ld  = 1'b0;
  endtask

  // Entered and left on a negedge with the DUT idle.
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] len, input bit hold, input logic [1:0] hop);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] e;
    int               exp_busy;
    int               busy_n;
    bit               prev_busy;
    bit               fin;
    m        = q;
    exp_busy = 0;
    case (op)
      2'b00: begin m = data; exp_q.push_back(m); exp_busy = 1; end
      2'b11: begin m = '0;   exp_q.push_back(m); exp_busy = 1; end
      default: begin
        for (int s = 0; s < int'(len); s++) begin
          exp_busy++;
          if (SAT && (((op == 2'b01) && (m == 4'hF)) || ((op == 2'b10) && (m == 4'h0)))) begin
            exp_q.push_back(m);
            break;
          end
          m = (op == 2'b01) ? m + 4'd1 : m - 4'd1;
          exp_q.push_back(m);
        end
      end
    endcase

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    chk("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = hold;
    if (hold) begin
      cmd_op   = hop;
      cmd_data = ~data;
      cmd_len  = 8'd7;
    end

    prev_busy = 1'b0;
    busy_n    = 0;
    fin       = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("extra_edge", {28'd0, q}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("q_step", {28'd0, q}, {28'd0, e});
        end
      end
      if (busy && (op == 2'b00)) begin
        chk("load_j", {28'd0, j}, {28'd0, data});
        chk("load_k", {28'd0, k}, {28'd0, ~data});
      end
      if (busy && (op == 2'b11)) begin
        chk("clear_j", {28'd0, j}, 32'h0);
        chk("clear_k", {28'd0, k}, 32'hF);
      end
      if (busy) busy_n++;
      if (done) begin
        fin = 1'b1;
        chk("done_jk", {24'd0, j, k}, 32'h0);
        chk("done_ready", {31'd0, cmd_ready}, 32'd0);
      end
      prev_busy = busy;
    end
    if (!fin) chk("timeout_done", 32'd0, 32'd1);
    chk("busy_cycles", busy_n, exp_busy);
    chk("sb_left", exp_q.size(), 0);
    chk("q_final", {28'd0, q}, {28'd0, m});
    exp_q.delete();
    @(negedge clk);
    chk("done_width", {31'd0, done}, 32'd0);
    chk("ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_len   = '0;
    bank_ld   = 1'b1;
    bank_val  = 4'b1010;
    repeat (2) @(negedge clk);
    bank_ld = 1'b0;
    rst_n   = 1'b1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_jk",    {24'd0, j, k}, 32'h0);

    // Reset asserted mid-RUN of a LOAD: outputs drop at once, bank keeps 1010.
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0101;
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("arst_jk",    {24'd0, j, k}, 32'h0);
    chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_done",  {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    chk("arst_hold", {28'd0, q}, 32'hA);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(2'b00, 4'b0110, 8'd0, 1'b0, 2'b00);
    set_bank(4'b0011);
    run_cmd(2'b01, 4'b0000, 8'd5, 1'b0, 2'b00);
    set_bank(4'b0001);
    run_cmd(2'b10, 4'b0000, 8'd3, 1'b0, 2'b00);
    set_bank(4'b1111);
    run_cmd(2'b11, 4'b0000, 8'd0, 1'b0, 2'b00);
    run_cmd(2'b01, 4'b0000, 8'd0, 1'b0, 2'b00);
    set_bank(4'b1110);
    run_cmd(2'b01, 4'b0000, 8'd3, 1'b0, 2'b00);
    set_bank(4'b1001);
    run_cmd(2'b10, 4'b0000, 8'd2, 1'b0, 2'b00);

    // Valid held through RUN with a CLEAR pending; it must only be taken once idle.
    set_bank(4'b0000);
    run_cmd(2'b00, 4'b0101, 8'd0, 1'b1, 2'b11);
    run_cmd(2'b11, 4'b1010, 8'd7, 1'b0, 2'b00);

    // Reset three steps into a long up-count: bank stops at start+3, no done.
    set_bank(4'b0010);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_len   = 8'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_jk",   {24'd0, j, k}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    chk("abort_q", {28'd0, q}, 32'h5);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_bank_sched.md
Name: jk_bank_sched

Overview:
- Sequencer for a bank of WIDTH JK flip-flops, each built from the team's existing JK flip-flop cell.
- Accepts commands over a valid/ready handshake: LOAD, COUNT_UP, COUNT_DOWN, CLEAR.
- Drives per-bit J/K every cycle so that the external bank loads, clears, or counts for a programmed number of clock edges.
- Reads bank state back on Q. Sits between a command source (switches/host FSM) and the flip-flop bank.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- CNT_W, 8, width of the step-count field.

Ports:
- CLK  in  1  clock; bank and block both sample on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 CLEAR.
- cmd_data  in  WIDTH  LOAD value.
- cmd_len  in  CNT_W  number of count steps (COUNT_UP/COUNT_DOWN only).
- Q  in  WIDTH  current bank outputs (feedback).
- J  out  WIDTH  J inputs to the bank.
- K  out  WIDTH  K inputs to the bank.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (RST_n=0, asynchronous):
  - State IDLE; J=0, K=0 (bank holds).
  - cmd_ready=1, busy=0, done=0.
  - Latched op/data/step counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, J=K=0.
  - On the edge where cmd_valid & cmd_ready: latch op, data and len into step counter; go to RUN.
  - Exception: op is COUNT_UP/COUNT_DOWN with cmd_len=0 → go directly to DONE. No bank edge is driven.
- RUN:
  - cmd_ready=0, busy=1. J/K are combinational from latched op and live Q.
  - LOAD: J=data, K=~data. One edge, then DONE.
  - CLEAR: J=0, K=all ones. One edge, then DONE.
  - COUNT_UP: bit i gets J=K=1 iff Q[i-1:0] all ones (bit 0 always toggles); else J=K=0.
  - COUNT_DOWN: bit i gets J=K=1 iff Q[i-1:0] all zeros (bit 0 always toggles); else J=K=0.
  - Counting: step counter decrements each edge in RUN. On the edge where counter==1, go to DONE. Exactly len bank edges are driven.
  - Wrap-around: without the optional feature, up from all-ones gives 0 and down from 0 gives all-ones.
- DONE:
  - Exactly one cycle; done=1, J=K=0, cmd_ready=0, busy=0. Then IDLE.
- Command latency: acceptance edge → first bank-driving edge is 1 cycle later. done asserts the cycle after the last bank edge.
- Ignored inputs:
  - cmd_valid outside IDLE is ignored; commands are never queued.
  - cmd_data, cmd_len and cmd_op are sampled only at acceptance.
- Reset mid-RUN: outputs go immediately to reset values and the command is abandoned. Bank contents are whatever the last completed edge produced; no done pulse.
- Q is assumed stable before each rising edge; no internal copy of bank state is kept.

Optional Feature:
- Macro JK_BANK_SCHED_SAT_EN.
- Defined: counting saturates.
  - In COUNT_UP, if Q is all ones at a RUN cycle, drive J=K=0 and go to DONE on that edge, even if steps remain.
  - In COUNT_DOWN, same behaviour when Q is all zeros.
- Undefined: counting wraps as above; the command always runs len edges.
- LOAD/CLEAR are identical in both builds.

Test Plan:
- Reset with bank Q=4'b1010, then RST_n=0 mid-cycle → J=K=0 and cmd_ready=1 immediately, done=0, bank holds 1010.
- LOAD cmd_data=4'b0110 → one RUN cycle with J=0110, K=1001; Q=0110 after the edge; done pulses the next cycle; cmd_ready returns 1 the cycle after done.
- From Q=0011, COUNT_UP len=5 → Q sequence 0100, 0101, 0110, 0111, 1000; busy high exactly 5 cycles; done once.
- From Q=0001, COUNT_DOWN len=3:
  - Default build → 0000, 1111, 1110.
  - With JK_BANK_SCHED_SAT_EN → 0000 then DONE after 2 cycles; Q stays 0000.
- CLEAR from Q=1111 → Q=0000 after one edge. Then COUNT_UP len=0 → DONE next cycle, no Q change.
- cmd_valid held high during RUN with a different op → ignored; after done, the still-held command is accepted once cmd_ready=1. Separately: pulse RST_n low during COUNT_UP len=10 after 3 steps → count stops at start+3, no done.
